// File: rtl/nes_controller_reader_pkg.sv
// rtl/nes_controller_reader_pkg.sv - scan FSM encoding and button bit positions
package nes_controller_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_READ_LO = 3'd2,
    ST_READ_HI = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_t;

  // Bit positions in the button word, shared with the UI and screen modules
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_controller_reader_sync2.sv
// rtl/nes_controller_reader_sync2.sv - two-flop synchronizer, resets to 1 (released level)
module nes_controller_reader_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_controller_reader.sv
// rtl/nes_controller_reader.sv - polls an NES controller and publishes a per-frame button snapshot
module nes_controller_reader
  import nes_controller_reader_pkg::*;
#(
  parameter int HALF        = 600,
  parameter int POLL_PERIOD = 1666667
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_data,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic [7:0] new_press
);

  localparam int PW = $clog2(2 * HALF);
  localparam int IW = $clog2(POLL_PERIOD);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF - 1);
  localparam logic [IW-1:0] POLL_LAST  = IW'(POLL_PERIOD - 1);

  scan_state_t   state;
  logic [IW-1:0] idle_cnt;
  logic [PW-1:0] phase;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          data_sync;

  nes_controller_reader_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ctrl_data),
    .q     (data_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      idle_cnt      <= '0;
      phase         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      ctrl_latch    <= 1'b0;
      ctrl_clk      <= 1'b0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      new_press     <= '0;
    end else begin
      buttons_valid <= 1'b0;
      new_press     <= '0;
      case (state)
        ST_IDLE: begin
          if (idle_cnt == POLL_LAST) begin
            idle_cnt   <= '0;
            phase      <= '0;
            ctrl_latch <= 1'b1;
            state      <= ST_LATCH;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        ST_LATCH: begin
          if (phase == LATCH_LAST) begin
            phase      <= '0;
            bit_idx    <= '0;
            ctrl_latch <= 1'b0;
            state      <= ST_READ_LO;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        ST_READ_LO: begin
          if (phase == HALF_LAST) begin
            phase          <= '0;
            shift[bit_idx] <= data_sync;
            if (bit_idx == 3'd7) begin
              state <= ST_DONE;
            end else begin
              ctrl_clk <= 1'b1;
              state    <= ST_READ_HI;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        ST_READ_HI: begin
          if (phase == HALF_LAST) begin
            phase    <= '0;
            ctrl_clk <= 1'b0;
            bit_idx  <= bit_idx + 3'd1;
            state    <= ST_READ_LO;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        ST_DONE: begin
          // buttons always equals the previous published snapshot, so it doubles as the edge reference
          buttons       <= ~shift;
          new_press     <= ~shift & ~buttons;
          buttons_valid <= 1'b1;
          idle_cnt      <= '0;
          phase         <= '0;
          state         <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_controller_reader.sv
// tb/tb_nes_controller_reader.sv - directed frame vectors against a behavioural controller pad
module tb_nes_controller_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ctrl_data;
  logic       ctrl_latch;
  logic       ctrl_clk;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic [7:0] new_press;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] pad = 8'h00;
  logic       toggle_mode = 1'b0;
  logic [2:0] pos = 3'd0;
  logic       tog = 1'b1;

  nes_controller_reader #(.HALF(4), .POLL_PERIOD(100)) dut (
    .clk           (clk),
    .reset         (reset),
    .ctrl_data     (ctrl_data),
    .ctrl_latch    (ctrl_latch),
    .ctrl_clk      (ctrl_clk),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .new_press     (new_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 4021-style pad: latch loads bit 0, each ctrl_clk rise advances one bit
  always @(posedge ctrl_latch or posedge ctrl_clk) begin
    if (ctrl_latch) pos = 3'd0;
    else pos = pos + 3'd1;
  end

  // Alternate source: settles to the bit value shortly after each low phase starts, flips mid high phase
  always begin
    @(negedge ctrl_latch or negedge ctrl_clk or posedge ctrl_clk);
    if (ctrl_clk === 1'b1) begin
      #7;
      tog = ~tog;
    end else begin
      #3;
      tog = ~pad[pos];
    end
  end

  assign ctrl_data = toggle_mode ? tog : ~pad[pos];

  typedef struct {
    logic [7:0] pad;
    logic       tog;
    logic [7:0] exp_b;
    logic [7:0] exp_np;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] exp_b, input logic [7:0] exp_np);
    int  t0;
    bit  found;
    t0 = -1;
    found = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (ctrl_latch && t0 < 0) t0 = cyc;
      if (buttons_valid) begin
        found = 1;
        break;
      end
    end
    check({tag, "_valid_seen"}, found, 1);
    if (found) begin
      check({tag, "_latency"}, cyc - t0, 69);
      check({tag, "_buttons"}, buttons, exp_b);
      check({tag, "_new_press"}, new_press, exp_np);
      check({tag, "_no_x"}, $isunknown({buttons, new_press, ctrl_latch, ctrl_clk}), 0);
      tick();
      check({tag, "_valid_drop"}, buttons_valid, 0);
      check({tag, "_new_press_clear"}, new_press, 0);
      check({tag, "_buttons_hold"}, buttons, exp_b);
    end
  endtask

  initial begin
    int n;
    int t0;
    int w;
    int pulses;
    int hw;
    bit found;
    bit seen_valid;
    logic prevc;

    vecs[0] = '{8'h00, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{8'h09, 1'b0, 8'h09, 8'h09};
    vecs[2] = '{8'h09, 1'b0, 8'h09, 8'h00};
    vecs[3] = '{8'h10, 1'b0, 8'h10, 8'h10};
    vecs[4] = '{8'h30, 1'b0, 8'h30, 8'h20};
    vecs[5] = '{8'h00, 1'b0, 8'h00, 8'h00};
    vecs[6] = '{8'hA5, 1'b1, 8'hA5, 8'hA5};
    vecs[7] = '{8'hFF, 1'b1, 8'hFF, 8'h5A};
    vecs[8] = '{8'h00, 1'b0, 8'h00, 8'h00};

    reset = 1'b1;
    repeat (5) tick();
    check("rst_latch", ctrl_latch, 0);
    check("rst_clk", ctrl_clk, 0);
    check("rst_buttons", buttons, 0);
    check("rst_valid", buttons_valid, 0);
    check("rst_new_press", new_press, 0);

    // First scan after reset, inspected cycle by cycle
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (ctrl_latch) break;
    end
    check("first_latch_delay", n, 100);
    t0 = cyc;
    w = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!ctrl_latch) break;
      w++;
    end
    check("latch_width", w, 8);
    pulses = 0;
    hw = 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (ctrl_clk) begin
        hw++;
      end else if (hw > 0) begin
        check("clk_high_width", hw, 4);
        pulses++;
        hw = 0;
      end
      if (buttons_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    check("first_valid_seen", found, 1);
    check("clk_pulse_count", pulses, 7);
    check("first_latency", cyc - t0, 69);
    check("first_buttons", buttons, 0);
    check("first_new_press", new_press, 0);
    tick();
    check("first_valid_drop", buttons_valid, 0);

    for (int v = 0; v < 9; v++) begin
      pad = vecs[v].pad;
      toggle_mode = vecs[v].tog;
      run_frame($sformatf("vec%0d", v), vecs[v].exp_b, vecs[v].exp_np);
    end

    // Reset during the high phase of bit 4
    pad = 8'h09;
    toggle_mode = 1'b0;
    run_frame("pre_reset", 8'h09, 8'h09);
    pulses = 0;
    prevc = 1'b0;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ctrl_clk && !prevc) pulses++;
      prevc = ctrl_clk;
      if (pulses == 5) begin
        found = 1;
        break;
      end
    end
    check("midscan_reached", found, 1);
    check("midscan_buttons_before", buttons, 8'h09);
    reset = 1'b1;
    tick();
    check("midscan_rst_clk", ctrl_clk, 0);
    check("midscan_rst_latch", ctrl_latch, 0);
    check("midscan_rst_buttons", buttons, 0);
    check("midscan_rst_valid", buttons_valid, 0);
    reset = 1'b0;
    n = 0;
    seen_valid = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (buttons_valid) seen_valid = 1;
      if (ctrl_latch) break;
    end
    check("post_reset_latch_delay", n, 100);
    t0 = cyc;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (buttons_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    check("post_reset_no_early_valid", seen_valid, 0);
    check("post_reset_valid_seen", found, 1);
    check("post_reset_latency", cyc - t0, 69);
    check("post_reset_buttons", buttons, 8'h09);
    check("post_reset_new_press", new_press, 8'h09);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
